// File: rtl/sram_arb_2to1_pkg.sv
// Shared types and helpers for the two-host SRAM arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_arb_pkg;

    // Host identity; the encoding matches the arbiter's req/gnt bit index.
    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_e;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    // True when addr lies in the power-of-two window that starts at base.
    function automatic logic addr_in_window(input logic [AddrW-1:0] addr,
                                            input logic [AddrW-1:0] base,
                                            input logic [AddrW-1:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/sram_arb_2to1_if.sv
// Bundle of the instr host, data host and SRAM signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: a host holds req stable until it sees gnt.
interface sram_arb_2to1_if;
    import sram_arb_pkg::*;

    logic             instr_req_i;
    logic             instr_gnt_o;
    logic             instr_rvalid_o;
    logic             instr_err_o;
    logic [AddrW-1:0] instr_addr_i;
    logic [DataW-1:0] instr_rdata_o;

    logic             data_req_i;
    logic             data_gnt_o;
    logic             data_rvalid_o;
    logic             data_err_o;
    logic             data_we_i;
    logic [3:0]       data_be_i;
    logic [AddrW-1:0] data_addr_i;
    logic [DataW-1:0] data_wdata_i;
    logic [DataW-1:0] data_rdata_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic [3:0]       mem_be_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [DataW-1:0] mem_wdata_o;
    logic             mem_rvalid_i;
    logic [DataW-1:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i
    );

    // Hosts plus SRAM side (what drives the arbiter).
    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/sram_arb_2to1_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 = instr, bit 1 = data.
// Latency: grant is combinational in the request cycle.
// Backpressure: the losing requester sees gnt=0 and must hold its request.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    host_e r_last_winner;

    // Sole requester wins; on contention the host that lost last time wins.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (r_last_winner == HostData) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Remember who won, only on cycles that actually grant; DATA after reset
    // so that INSTR takes the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_winner <= HostData;
        end else if (o_gnt[0]) begin
            r_last_winner <= HostInstr;
        end else if (o_gnt[1]) begin
            r_last_winner <= HostData;
        end
    end

endmodule

// File: rtl/sram_arb_2to1.sv
// OBI arbiter sharing one single-port SRAM between Ibex instr and data ports.
// Latency: grant same cycle as req; rvalid/rdata/err exactly one cycle later.
// Backpressure: loser's gnt stays low; one accepted request per cycle, no buffering.
module sram_arb_2to1
    import sram_arb_pkg::*;
#(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter int unsigned MemSize  = 65536
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sram_arb_2to1_if.slave    bus
);

    localparam logic [AddrW-1:0] AddrMask = AddrW'(MemSize - 1);

    logic [1:0]       w_gnt;
    logic             w_any_gnt;
    logic             w_data_won;
    host_e            w_winner;
    logic [AddrW-1:0] w_addr;
    logic             w_in_range;
    logic             w_mem_go;
    logic             w_mem_data;

    host_e            r_rsp_owner;
    logic             r_rsp_valid;
    logic             r_rsp_err;

    rr_arb2 u_rr_arb2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_req  ({bus.data_req_i, bus.instr_req_i}),
        .o_gnt  (w_gnt)
    );

    // Grant is one-hot, so the data bit alone identifies the winner.
    assign w_any_gnt  = |w_gnt;
    assign w_data_won = w_gnt[1];
    assign w_winner   = w_data_won ? HostData : HostInstr;
    assign w_addr     = w_data_won ? bus.data_addr_i : bus.instr_addr_i;
    assign w_in_range = addr_in_window(w_addr, MemStart, AddrMask);
    assign w_mem_go   = w_any_gnt && w_in_range;
    assign w_mem_data = w_mem_go && w_data_won;

    assign bus.instr_gnt_o = w_gnt[0];
    assign bus.data_gnt_o  = w_gnt[1];

    // Out-of-range grants never reach the SRAM; write fields only from data.
    assign bus.mem_req_o   = w_mem_go;
    assign bus.mem_addr_o  = w_mem_go   ? (w_addr & AddrMask) : '0;
    assign bus.mem_we_o    = w_mem_data && bus.data_we_i;
    assign bus.mem_be_o    = w_mem_data ? bus.data_be_i    : 4'b0000;
    assign bus.mem_wdata_o = w_mem_data ? bus.data_wdata_i : '0;

    // One-stage response tracker, reloaded every cycle; reset drops any
    // response still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= HostInstr;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_any_gnt;
            r_rsp_owner <= w_winner;
            r_rsp_err   <= w_any_gnt && !w_in_range;
        end
    end

    // Route the response to its owner; error responses carry zero data.
    always_comb begin
        bus.instr_rvalid_o = 1'b0;
        bus.instr_err_o    = 1'b0;
        bus.instr_rdata_o  = '0;
        bus.data_rvalid_o  = 1'b0;
        bus.data_err_o     = 1'b0;
        bus.data_rdata_o   = '0;
        if (r_rsp_valid) begin
            if (r_rsp_owner == HostData) begin
                bus.data_rvalid_o = 1'b1;
                bus.data_err_o    = r_rsp_err;
                bus.data_rdata_o  = r_rsp_err ? '0 : bus.mem_rdata_i;
            end else begin
                bus.instr_rvalid_o = 1'b1;
                bus.instr_err_o    = r_rsp_err;
                bus.instr_rdata_o  = r_rsp_err ? '0 : bus.mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_arb_2to1.sv
// Directed bench for sram_arb_2to1 with a 1-cycle-latency SRAM model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units later.
// Backpressure: hosts hold req until granted.
module tb_sram_arb_2to1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_arb_2to1_if bus ();

    sram_arb_2to1 #(
        .MemStart (32'h0000_0000),
        .MemSize  (65536)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // SRAM model: byte-enabled writes, read data one cycle after request.
    logic [31:0] mem [0:4095];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_rvalid_i <= 1'b0;
            bus.mem_rdata_i  <= 32'h0;
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[32'h80 >> 2]   <= 32'h0000_0013;
            mem[32'h100 >> 2]  <= 32'h1111_0100;
            mem[32'h2000 >> 2] <= 32'h2222_2000;
        end else begin
            bus.mem_rvalid_i <= bus.mem_req_o;
            if (bus.mem_req_o) begin
                bus.mem_rdata_i <= mem[bus.mem_addr_o[13:2]];
                if (bus.mem_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be_o[b])
                            mem[bus.mem_addr_o[13:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SRAM returns data exactly when a non-error response is due.
    task automatic chk_inv(input string tag);
        logic exp_v;
        exp_v = (bus.instr_rvalid_o | bus.data_rvalid_o) & ~(bus.instr_err_o | bus.data_err_o);
        chk(tag, {31'b0, bus.mem_rvalid_i}, {31'b0, exp_v});
    endtask

    task automatic idle();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = 32'h0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'h0;
        bus.data_addr_i  = 32'h0;
        bus.data_wdata_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr_gnt",    bus.instr_gnt_o,    0);
        chk("rst_data_gnt",     bus.data_gnt_o,     0);
        chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("rst_data_rvalid",  bus.data_rvalid_o,  0);
        chk("rst_mem_req",      bus.mem_req_o,      0);
        chk("rst_mem_addr",     bus.mem_addr_o,     0);
        chk("rst_data_err",     bus.data_err_o,     0);

        // Sustained contention: I, D, I, D with responses one cycle later.
        tick();
        rst_n = 1'b1;
        bus.instr_req_i  = 1'b1; bus.instr_addr_i = 32'h100;
        bus.data_req_i   = 1'b1; bus.data_addr_i  = 32'h2000;
        #2;
        chk("cont0_instr_gnt", bus.instr_gnt_o, 1);
        chk("cont0_data_gnt",  bus.data_gnt_o,  0);
        chk("cont0_mem_addr",  bus.mem_addr_o,  32'h100);
        chk("cont0_rvalid",    bus.instr_rvalid_o | bus.data_rvalid_o, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            #2;
            if (k % 2 == 1) begin
                chk("cont_data_gnt",     bus.data_gnt_o,     1);
                chk("cont_instr_gnt",    bus.instr_gnt_o,    0);
                chk("cont_mem_addr_d",   bus.mem_addr_o,     32'h2000);
                chk("cont_instr_rvalid", bus.instr_rvalid_o, 1);
                chk("cont_instr_rdata",  bus.instr_rdata_o,  32'h1111_0100);
                chk("cont_data_rvalid0", bus.data_rvalid_o,  0);
            end else begin
                chk("cont_instr_gnt2",   bus.instr_gnt_o,    1);
                chk("cont_data_gnt2",    bus.data_gnt_o,     0);
                chk("cont_data_rvalid",  bus.data_rvalid_o,  1);
                chk("cont_data_rdata",   bus.data_rdata_o,   32'h2222_2000);
                chk("cont_instr_rvalid0", bus.instr_rvalid_o, 0);
            end
            chk_inv("cont_inv");
        end
        tick();
        idle();
        #2;
        chk("cont_tail_data_rvalid",  bus.data_rvalid_o,  1);
        chk("cont_tail_data_rdata",   bus.data_rdata_o,   32'h2222_2000);
        chk("cont_tail_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("cont_tail_mem_req",      bus.mem_req_o,      0);

        // Instr-only read at 0x80.
        tick();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h80;
        #2;
        chk("ird_gnt",      bus.instr_gnt_o, 1);
        chk("ird_data_gnt", bus.data_gnt_o,  0);
        chk("ird_mem_req",  bus.mem_req_o,   1);
        chk("ird_mem_addr", bus.mem_addr_o,  32'h80);
        chk("ird_mem_we",   bus.mem_we_o,    0);
        tick();
        idle();
        #2;
        chk("ird_rvalid",      bus.instr_rvalid_o, 1);
        chk("ird_rdata",       bus.instr_rdata_o,  32'h0000_0013);
        chk("ird_err",         bus.instr_err_o,    0);
        chk("ird_data_rvalid", bus.data_rvalid_o,  0);
        chk("ird_data_rdata",  bus.data_rdata_o,   0);
        chk_inv("ird_inv");

        // Partial write then readback at 0x40.
        tick();
        bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
        bus.data_addr_i = 32'h40; bus.data_wdata_i = 32'hDEAD_BEEF;
        #2;
        chk("wr_gnt",       bus.data_gnt_o,  1);
        chk("wr_mem_we",    bus.mem_we_o,    1);
        chk("wr_mem_be",    bus.mem_be_o,    32'h3);
        chk("wr_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        chk("wr_mem_addr",  bus.mem_addr_o,  32'h40);
        tick();
        bus.data_we_i = 1'b0; bus.data_be_i = 4'hF; bus.data_wdata_i = 32'h0;
        #2;
        chk("wr_rsp_rvalid", bus.data_rvalid_o, 1);
        chk("wr_rsp_err",    bus.data_err_o,    0);
        chk("rd_gnt",        bus.data_gnt_o,    1);
        chk("rd_mem_we",     bus.mem_we_o,      0);
        tick();
        idle();
        #2;
        chk("rd_rvalid", bus.data_rvalid_o, 1);
        chk("rd_rdata",  bus.data_rdata_o,  32'h0000_BEEF);
        chk_inv("rd_inv");

        // Out-of-range data read, with an instr grant overlapping its response.
        tick();
        bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0001_0000;
        #2;
        chk("oor_gnt",      bus.data_gnt_o, 1);
        chk("oor_mem_req",  bus.mem_req_o,  0);
        chk("oor_mem_addr", bus.mem_addr_o, 0);
        tick();
        idle();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h80;
        #2;
        chk("oor_rvalid",       bus.data_rvalid_o,  1);
        chk("oor_err",          bus.data_err_o,     1);
        chk("oor_rdata",        bus.data_rdata_o,   0);
        chk("oor_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("ovl_instr_gnt",    bus.instr_gnt_o,    1);
        chk("ovl_mem_req",      bus.mem_req_o,      1);
        chk_inv("oor_inv");
        tick();
        idle();
        #2;
        chk("ovl_instr_rvalid", bus.instr_rvalid_o, 1);
        chk("ovl_instr_rdata",  bus.instr_rdata_o,  32'h0000_0013);
        chk("ovl_instr_err",    bus.instr_err_o,    0);

        // Reset right after an instr grant: response dropped, INSTR wins next.
        tick();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h80;
        #2;
        chk("prerst_gnt", bus.instr_gnt_o, 1);
        tick();
        idle();
        rst_n = 1'b0;
        #2;
        chk("inrst_instr_rvalid", bus.instr_rvalid_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        chk("postrst_instr_rvalid", bus.instr_rvalid_o, 0);
        chk("postrst_data_rvalid",  bus.data_rvalid_o,  0);
        tick();
        bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h100;
        bus.data_req_i  = 1'b1; bus.data_addr_i  = 32'h2000;
        #2;
        chk("postrst_idle_rvalid", bus.instr_rvalid_o | bus.data_rvalid_o, 0);
        chk("postrst_instr_gnt",   bus.instr_gnt_o, 1);
        chk("postrst_data_gnt",    bus.data_gnt_o,  0);
        tick();
        idle();
        #2;
        chk("postrst_instr_rsp", bus.instr_rvalid_o, 1);
        chk("postrst_rdata",     bus.instr_rdata_o,  32'h1111_0100);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
